// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes,
// ALU/mux select codes and fault codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RST       = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_RD    = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WR    = 4'd6,
        ST_EXEC      = 4'd7,
        ST_ALU_WB    = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_ADDI_EXEC = 4'd11,
        ST_ADDI_WB   = 4'd12,
        ST_FAULT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUSRCB_RT      = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory wait state; expired flags
// the last cycle allowed before the controller gives up on the access.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (clear)
            wait_cnt <= '0;
        else if (enable)
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign expired = (wait_cnt == LAST);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore sequencer for the multi-cycle MIPS datapath with a shared memory port.
//   state      | meaning
//   RST        | post-reset, all controls low
//   FETCH      | read instruction at PC, PC <= PC+4 on ready
//   DECODE     | branch target into ALU out, dispatch on opcode
//   MEM_ADDR   | rs + imm address for lw/sw
//   MEM_RD     | data read, waits for ready
//   MEM_WB     | load data into rt
//   MEM_WR     | data write, waits for ready
//   EXEC       | R-type ALU op
//   ALU_WB     | ALU out into rd
//   BRANCH     | beq compare, PC <= target if zero
//   JUMP       | PC <= jump target
//   ADDI_EXEC  | rs + imm
//   ADDI_WB    | ALU out into rt
//   FAULT      | sticky, left only by reset
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_retired,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [3:0] state
);
    state_t     state_q, state_d;
    logic [1:0] code_q, code_d;
    logic       cnt_en;
    logic       expired;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_d != state_q),
        .enable  (cnt_en),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RST;
            code_q  <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        code_d        = code_q;
        cnt_en        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUSRCB_RT;
        alu_op        = ALU_OP_ADD;
        pc_source     = PCSRC_ALU;
        instr_retired = 1'b0;
        fault         = 1'b0;

        case (state_q)
            ST_RST: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUSRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready)
                    state_d = ST_DECODE;
                else if (expired) begin
                    state_d = ST_FAULT;
                    code_d  = FAULT_TIMEOUT;
                end else
                    cnt_en = 1'b1;
            end
            ST_DECODE: begin
                alu_src_b = ALUSRCB_IMM_SH2;
                case (opcode)
                    OP_RTYPE:      state_d = ST_EXEC;
                    OP_LW, OP_SW:  state_d = ST_MEM_ADDR;
                    OP_BEQ:        state_d = ST_BRANCH;
                    OP_J:          state_d = ST_JUMP;
                    OP_ADDI:       state_d = ST_ADDI_EXEC;
                    default: begin
                        state_d = ST_FAULT;
                        code_d  = FAULT_ILLEGAL;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_IMM;
                state_d   = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready)
                    state_d = ST_MEM_WB;
                else if (expired) begin
                    state_d = ST_FAULT;
                    code_d  = FAULT_TIMEOUT;
                end else
                    cnt_en = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write     = 1'b1;
                mem_to_reg    = 1'b1;
                instr_retired = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_write     = 1'b1;
                iord          = 1'b1;
                instr_retired = mem_ready;
                if (mem_ready)
                    state_d = ST_FETCH;
                else if (expired) begin
                    state_d = ST_FAULT;
                    code_d  = FAULT_TIMEOUT;
                end else
                    cnt_en = 1'b1;
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_FUNCT;
                state_d   = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                reg_write     = 1'b1;
                reg_dst       = 1'b1;
                instr_retired = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_OP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_retired = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write      = 1'b1;
                pc_source     = PCSRC_JUMP;
                instr_retired = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_IMM;
                state_d   = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_FAULT: fault = 1'b1;
            // 13 and 14 are never entered; treat as corruption
            default: begin
                state_d = ST_FAULT;
                code_d  = FAULT_ILLEGAL;
            end
        endcase
    end

    assign fault_code = code_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: instruction-level reference model queues per-cycle control
// words and instruction completion events; a monitor checks them at negedge.
module tb_mips_multicycle_ctrl;
    localparam int MEM_TIMEOUT = 15;

    typedef struct packed {
        logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
        logic       instr_retired, fault;
        logic [1:0] fault_code;
        logic [3:0] state;
    } ctl_t;

    typedef struct {
        bit         is_fault;
        int         len;
        logic [1:0] code;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_retired, fault;
    logic [1:0] fault_code;
    logic [3:0] state;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_retired(instr_retired), .fault(fault),
        .fault_code(fault_code), .state(state)
    );

    always #5 clk = ~clk;

    ctl_t exp_q[$];
    ev_t  ev_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    int         instr_len = 0;
    bit         in_fault = 0;
    bit         halted = 0;
    int         abort_left = -1;
    logic [1:0] exp_fc = 2'b00;

    logic [5:0] ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

    // Control word the spec lists for a given micro-step
    function automatic ctl_t expect_ctl(input int st, input logic rdy, input logic [1:0] fc);
        ctl_t c = '0;
        c.state = 4'(st);
        c.fault_code = fc;
        case (st)
            1:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            2:  c.alu_src_b = 2'b11;
            3:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4:  begin c.mem_read = 1; c.iord = 1; end
            5:  begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_retired = 1; end
            6:  begin c.mem_write = 1; c.iord = 1; c.instr_retired = rdy; end
            7:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            8:  begin c.reg_write = 1; c.reg_dst = 1; c.instr_retired = 1; end
            9:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                      c.pc_source = 2'b01; c.instr_retired = 1; end
            10: begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_retired = 1; end
            11: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            12: begin c.reg_write = 1; c.instr_retired = 1; end
            15: c.fault = 1;
            default: c.fault_code = 2'b00;
        endcase
        return c;
    endfunction

    task automatic cycle(input logic [5:0] op, input logic rdy, input int st);
        ctl_t e;
        @(posedge clk); #1;
        reset = 1'b0; opcode = op; mem_ready = rdy;
        e = expect_ctl(st, rdy, exp_fc);
        instr_len++;
        exp_q.push_back(e);
        if (e.instr_retired) begin
            ev_q.push_back('{0, instr_len, 2'b00});
            instr_len = 0;
        end
        if (e.fault && !in_fault) ev_q.push_back('{1, instr_len, exp_fc});
        in_fault = e.fault;
        if (abort_left > 0) abort_left--;
    endtask

    task automatic tick(input logic [5:0] op, input int st, input logic rdy);
        if (halted) return;
        if (abort_left == 0) begin halted = 1; return; end
        cycle(op, rdy, st);
    endtask

    task automatic wait_step(input logic [5:0] op, input int st, input int stalls);
        for (int i = 0; i < stalls && i < MEM_TIMEOUT; i++) tick(op, st, 1'b0);
        if (stalls >= MEM_TIMEOUT) begin
            if (!halted && abort_left != 0) exp_fc = 2'b10;
            tick(op, 15, 1'($urandom));
            halted = 1;
        end else begin
            tick(op, st, 1'b1);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; opcode = 6'($urandom); mem_ready = 1'($urandom);
        exp_fc = 2'b00; in_fault = 0; instr_len = 0; halted = 0; abort_left = -1;
        exp_q.push_back(expect_ctl(0, 1'b0, 2'b00));
        @(negedge clk); #1;
        reset = 1'b0;
    endtask

    // Micro-step sequence for one instruction, derived from the opcode rules
    task automatic run_instr(input logic [5:0] op, input int s_fetch, input int s_mem, input int abort_at);
        halted = 0;
        abort_left = abort_at;
        wait_step(op, 1, s_fetch);
        tick(op, 2, 1'($urandom));
        case (op)
            6'b000000: begin tick(op, 7, 1'($urandom)); tick(op, 8, 1'($urandom)); end
            6'b100011: begin tick(op, 3, 1'($urandom)); wait_step(op, 4, s_mem); tick(op, 5, 1'($urandom)); end
            6'b101011: begin tick(op, 3, 1'($urandom)); wait_step(op, 6, s_mem); end
            6'b000100: tick(op, 9, 1'($urandom));
            6'b000010: tick(op, 10, 1'($urandom));
            6'b001000: begin tick(op, 11, 1'($urandom)); tick(op, 12, 1'($urandom)); end
            default: begin
                if (!halted && abort_left != 0) exp_fc = 2'b01;
                tick(op, 15, 1'($urandom));
            end
        endcase
        if (in_fault) begin
            repeat ($urandom_range(1, 4)) cycle(6'($urandom), 1'($urandom), 15);
            do_reset();
        end else if (halted) begin
            do_reset();
        end
        abort_left = -1;
    endtask

    // Monitor
    initial begin
        ctl_t got, e;
        ev_t  ev;
        int   cnt = 0;
        logic fault_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            got = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source, instr_retired, fault, fault_code, state};
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL ctl cycle=%0d got=%h exp=%h (state got=%0d exp=%0d)",
                             cyc, got, e, got.state, e.state);
                end
            end
            if (reset) begin
                cnt = 0;
            end else begin
                cnt++;
                if (instr_retired || (fault && !fault_prev)) begin
                    tests++;
                    if (ev_q.size() == 0) begin
                        fails++;
                        $display("FAIL event_unexpected cycle=%0d retired=%0b fault=%0b exp=none",
                                 cyc, instr_retired, fault);
                    end else begin
                        ev = ev_q.pop_front();
                        if (ev.is_fault != (fault && !fault_prev) || ev.len != cnt || ev.code !== fault_code) begin
                            fails++;
                            $display("FAIL event cycle=%0d got fault=%0b len=%0d code=%0d exp fault=%0b len=%0d code=%0d",
                                     cyc, fault && !fault_prev, cnt, fault_code, ev.is_fault, ev.len, ev.code);
                        end
                    end
                    if (instr_retired) cnt = 0;
                end
            end
            fault_prev = fault;
        end
    end

    initial begin
        int r, sf, sm, ab;
        logic [5:0] op;
        do_reset();
        run_instr(6'b000000, 0, 0, -1);
        run_instr(6'b100011, 0, 3, -1);
        run_instr(6'b101011, 0, 2, -1);
        run_instr(6'b000100, 0, 0, -1);
        run_instr(6'b000010, 0, 0, -1);
        run_instr(6'b001000, 1, 0, -1);
        run_instr(6'b000000, MEM_TIMEOUT, 0, -1);
        run_instr(6'b000000, MEM_TIMEOUT - 1, 0, -1);
        run_instr(6'b100011, 0, MEM_TIMEOUT, -1);
        run_instr(6'b101011, 0, MEM_TIMEOUT - 1, -1);
        run_instr(6'b111111, 0, 0, -1);
        run_instr(6'b100011, 0, 2, 4);
        for (int n = 0; n < 150; n++) begin
            r  = $urandom_range(0, 7);
            op = (r < 6) ? ops[r] : 6'($urandom);
            sf = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 2);
            sm = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 3);
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : -1;
            run_instr(op, sf, sm, ab);
        end
        repeat (3) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL cycles_left got=%0d exp=0", exp_q.size());
        end
        tests++;
        if (ev_q.size() != 0) begin
            fails++;
            $display("FAIL events_left got=%0d exp=0", ev_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
